// File: rtl/machine_timer_pkg.sv
// -----------------------------------------------------------------------------
// machine_timer_pkg
// Shared types and constants for the RISC-V machine timer agent.
//   timer_reg_e     : register index decoded from address[4:2]
//   MTIMECMP_RESET  : compare value after reset (interrupt cannot fire)
//   CTRL_EN_BIT     : position of the counter enable bit in CTRL
// -----------------------------------------------------------------------------
package machine_timer_pkg;

    typedef enum logic [2:0] {
        MTIME_LO    = 3'd0,
        MTIME_HI    = 3'd1,
        MTIMECMP_LO = 3'd2,
        MTIMECMP_HI = 3'd3,
        CTRL        = 3'd4
    } timer_reg_e;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          CTRL_EN_BIT    = 0;

endpackage

// File: rtl/machine_timer_tick.sv
// -----------------------------------------------------------------------------
// tick_divider
// Prescaler for the machine timer: produces one tick every PRESCALE enabled
// clock cycles. The counter runs 0..PRESCALE-1 and the tick is asserted while
// it sits at PRESCALE-1. With en=0 the counter holds its value.
//   clk  in  system clock
//   rst  in  synchronous, active-high reset (counter -> 0)
//   en   in  count enable
//   tick out one-cycle increment strobe for mtime
// PRESCALE=1 degenerates to tick=en with no state.
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // No counter needed; clk/rst only feed a discarded reduction.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign tick = en;
        end else begin : g_count
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (en) begin
                    count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
                end
            end

            assign tick = en && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/machine_timer.sv
// -----------------------------------------------------------------------------
// machine_timer
// Avalon-MM read/write agent implementing a RISC-V machine timer
// (64-bit mtime / mtimecmp) with a level interrupt.
//   clk, rst        system clock, synchronous active-high reset
//   address[4:2]    register select (MTIME_LO/HI, MTIMECMP_LO/HI, CTRL)
//   read, write     requests, accepted when waitrequest=0 (write wins)
//   writedata       write data, byteenable selects the bytes written
//   readdata        read data, valid while readdatavalid=1, held otherwise
//   readdatavalid   one pulse per accepted read, fixed latency 1
//   waitrequest     high only from reset until the first cycle after it
//   timer_irq       registered (mtime >= mtimecmp)
// Build option MTIME_SNAPSHOT_EN: an MTIME_LO read latches mtime[63:32] into a
// shadow register that MTIME_HI reads return, for tear-free 64-bit reads.
// -----------------------------------------------------------------------------
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    output logic        timer_irq
);

    logic [63:0] mtime_reg, mtime_next;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic        en_reg, en_next;
    logic [31:0] readdata_reg;
    logic        readdatavalid_reg;
    logic        waitrequest_reg;
    logic        irq_reg;
    logic        tick;

    logic [2:0]  reg_idx;
    logic        accept_wr, accept_rd;
    logic [31:0] be_mask;
    logic [31:0] rd_data;

    logic unused_addr;
    assign unused_addr = ^{address[31:5], address[1:0]};

    assign reg_idx   = address[4:2];
    assign accept_wr = write && !waitrequest_reg;
    // A simultaneous write takes priority; the read is not accepted.
    assign accept_rd = read && !write && !waitrequest_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_mask
            assign be_mask[gi*8 +: 8] = {8{byteenable[gi]}};
        end
    endgenerate

    tick_divider #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en_reg),
        .tick (tick)
    );

    // Next-state: the increment is computed first, then a software write to
    // either half replaces the whole value with {written half, pre-edge other
    // half}, so a write on a tick edge suppresses that increment.
    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        en_next       = en_reg;

        if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end

        if (accept_wr) begin
            case (reg_idx)
                MTIME_LO: mtime_next = {mtime_reg[63:32],
                                        (mtime_reg[31:0] & ~be_mask) | (writedata & be_mask)};
                MTIME_HI: mtime_next = {(mtime_reg[63:32] & ~be_mask) | (writedata & be_mask),
                                        mtime_reg[31:0]};
                MTIMECMP_LO: mtimecmp_next = {mtimecmp_reg[63:32],
                                              (mtimecmp_reg[31:0] & ~be_mask) | (writedata & be_mask)};
                MTIMECMP_HI: mtimecmp_next = {(mtimecmp_reg[63:32] & ~be_mask) | (writedata & be_mask),
                                              mtimecmp_reg[31:0]};
                CTRL: begin
                    if (byteenable[0]) begin
                        en_next = writedata[CTRL_EN_BIT];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MTIME_SNAPSHOT_EN
    logic [31:0] shadow_hi_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_hi_reg <= '0;
        end else if (accept_rd && (reg_idx == MTIME_LO)) begin
            shadow_hi_reg <= mtime_reg[63:32];
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            MTIME_LO:    rd_data = mtime_reg[31:0];
`ifdef MTIME_SNAPSHOT_EN
            MTIME_HI:    rd_data = shadow_hi_reg;
`else
            MTIME_HI:    rd_data = mtime_reg[63:32];
`endif
            MTIMECMP_LO: rd_data = mtimecmp_reg[31:0];
            MTIMECMP_HI: rd_data = mtimecmp_reg[63:32];
            CTRL:        rd_data = {31'd0, en_reg};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg         <= '0;
            mtimecmp_reg      <= MTIMECMP_RESET;
            en_reg            <= 1'b1;
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
            waitrequest_reg   <= 1'b1;
            irq_reg           <= 1'b0;
        end else begin
            mtime_reg         <= mtime_next;
            mtimecmp_reg      <= mtimecmp_next;
            en_reg            <= en_next;
            waitrequest_reg   <= 1'b0;
            readdatavalid_reg <= accept_rd;
            if (accept_rd) begin
                readdata_reg <= rd_data;
            end
            // Compare post-update values so the irq tracks the new state.
            irq_reg <= (mtime_next >= mtimecmp_next);
        end
    end

    assign readdata      = readdata_reg;
    // A response pending when reset arrives is dropped rather than delivered.
    assign readdatavalid = readdatavalid_reg && !rst;
    assign waitrequest   = waitrequest_reg;
    assign timer_irq     = irq_reg;

endmodule

// File: tb/tb_machine_timer.sv
// -----------------------------------------------------------------------------
// tb_machine_timer
// Directed test of machine_timer (PRESCALE=1). Inputs are driven and outputs
// sampled on the falling edge; every expected value is hand-derived from the
// number of rising edges since the last mtime write.
// -----------------------------------------------------------------------------
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    machine_timer #(.PRESCALE(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .timer_irq     (timer_irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // All bus tasks are entered on a falling edge and return on one.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        address    = addr;
        writedata  = data;
        byteenable = be;
        write      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write      = 1'b0;
        byteenable = 4'hF;
        $display("write addr=%h data=%h be=%b", addr, data, be);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        address = addr;
        read    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read    = 1'b0;
        check_eq({tag, "_valid"}, 64'(readdatavalid), 64'd1);
        check_eq(tag, 64'(readdata), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_waitrequest", 64'(waitrequest), 64'd1);
        check_eq("rst_rdv", 64'(readdatavalid), 64'd0);
        check_eq("rst_readdata", 64'(readdata), 64'd0);
        check_eq("rst_irq", 64'(timer_irq), 64'd0);
        rst = 1'b0;

        // Five counting edges, then a read accepted on the sixth sees 5
        idle(5);
        check_eq("waitrequest_low", 64'(waitrequest), 64'd0);
        check_eq("irq_idle", 64'(timer_irq), 64'd0);
        read_check("mtime_lo_after_reset", 32'h0, 32'd5);

        // Interrupt: mtime restarted at 0, compare at 20
        bus_write(32'h0, 32'h0, 4'hF);   // mtime = 0
        bus_write(32'h4, 32'h0, 4'hF);   // hi written, no increment: mtime = 0
        bus_write(32'hC, 32'h0, 4'hF);   // mtime = 1
        bus_write(32'h8, 32'd20, 4'hF);  // mtime = 2, cmp = 20
        check_eq("irq_below_cmp", 64'(timer_irq), 64'd0);
        idle(17);                        // mtime = 19
        check_eq("irq_at_19", 64'(timer_irq), 64'd0);
        idle(1);                         // mtime = 20
        check_eq("irq_at_20", 64'(timer_irq), 64'd1);
        read_check("mtime_lo_at_irq", 32'h0, 32'd20);
        check_eq("irq_held", 64'(timer_irq), 64'd1);
        bus_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        check_eq("irq_cleared", 64'(timer_irq), 64'd0);

        // Carry from lo into hi
        bus_write(32'h0, 32'hFFFF_FFFF, 4'hF);  // mtime = 0000_0000_FFFF_FFFF
        bus_write(32'h4, 32'h0, 4'hF);          // no increment on this edge
        idle(1);                                // mtime = 1_0000_0000
        check_eq("irq_after_carry", 64'(timer_irq), 64'd1);
        read_check("carry_lo", 32'h0, 32'd0);   // sees 1_0000_0000
        read_check("carry_hi", 32'h4, 32'd1);

        // Disable counting: the disabling edge still increments (to ..._0003)
        bus_write(32'h10, 32'h0, 4'hF);
        read_check("frozen_lo_1", 32'h0, 32'd3);
        idle(10);
        read_check("frozen_lo_2", 32'h0, 32'd3);
        bus_write(32'h0, 32'h0000_AB00, 4'b0010);
        read_check("byte1_write", 32'h0, 32'h0000_AB03);
        read_check("hi_untouched", 32'h4, 32'd1);

        // Unmapped register
        bus_write(32'h14, 32'h1234_5678, 4'hF);
        read_check("unmapped", 32'h14, 32'd0);

        // Three pipelined reads
        address = 32'h0;
        read    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_valid_0", 64'(readdatavalid), 64'd1);
        check_eq("b2b_data_0", 64'(readdata), 64'h0000_AB03);
        address = 32'h8;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_valid_1", 64'(readdatavalid), 64'd1);
        check_eq("b2b_data_1", 64'(readdata), 64'hFFFF_FFFF);
        address = 32'h1C;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        check_eq("b2b_valid_2", 64'(readdatavalid), 64'd1);
        check_eq("b2b_data_2", 64'(readdata), 64'd0);
        idle(1);
        check_eq("b2b_valid_end", 64'(readdatavalid), 64'd0);

`ifdef MTIME_SNAPSHOT_EN
        // Shadow keeps the hi half seen at the lo read
        bus_write(32'h4, 32'h0, 4'hF);
        bus_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        read_check("snap_lo", 32'h0, 32'hFFFF_FFFF);
        bus_write(32'h10, 32'h1, 4'hF);  // enable; no increment on this edge
        idle(1);                         // mtime = 1_0000_0000
        read_check("snap_hi", 32'h4, 32'd0);
        bus_write(32'h10, 32'h0, 4'hF);
`endif

        // Read and write together: write wins, no response
        address   = 32'h10;
        writedata = 32'h1;
        read      = 1'b1;
        write     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read      = 1'b0;
        write     = 1'b0;
        check_eq("rw_no_valid", 64'(readdatavalid), 64'd0);
        read_check("rw_ctrl", 32'h10, 32'd1);

        // Reset arriving in the response cycle of an accepted read
        address = 32'h0;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check_eq("rst_drop_valid", 64'(readdatavalid), 64'd0);
        idle(1);
        check_eq("rst2_valid", 64'(readdatavalid), 64'd0);
        check_eq("rst2_waitrequest", 64'(waitrequest), 64'd1);
        check_eq("rst2_readdata", 64'(readdata), 64'd0);
        check_eq("rst2_irq", 64'(timer_irq), 64'd0);
        rst = 1'b0;
        idle(1);
        check_eq("rst2_waitrequest_low", 64'(waitrequest), 64'd0);
        read_check("rst2_mtime_lo", 32'h0, 32'd1);
        read_check("rst2_mtime_hi", 32'h4, 32'd0);
        read_check("rst2_cmp_lo", 32'h8, 32'hFFFF_FFFF);
        read_check("rst2_cmp_hi", 32'hC, 32'hFFFF_FFFF);
        read_check("rst2_ctrl", 32'h10, 32'd1);
        check_eq("rst2_irq_low", 64'(timer_irq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
